// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the two-requester divider arbiter.
package div_arb_pkg;

    localparam int unsigned DIV_ARB_W_DEF       = 512;
    localparam int unsigned DIV_ARB_TIMEOUT_DEF = 1100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } div_arb_state_e;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/div_arb_rr.sv
// Two-way round-robin pick: a lone request wins, contention goes to the
// requester that was not served last.
module div_arb_rr
    import div_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    // winner selection
    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = owner_onehot(~last_i);
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external divider between two requesters (IDLE/LAUNCH/WAIT/RESP).
// Define DIV_TIMEOUT_EN to build in the WAIT watchdog that reports err.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned W              = DIV_ARB_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = DIV_ARB_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] dividend0,
    input  logic [W-1:0] divisor0,
    input  logic [W-1:0] dividend1,
    input  logic [W-1:0] divisor1,
    output logic [1:0]   grant,
    output logic [1:0]   done,
    output logic [W-1:0] q_out,
    output logic [W-1:0] rem_out,
    output logic         err,
    output logic         div_start,
    output logic [W-1:0] div_q,
    output logic [W-1:0] div_m,
    input  logic [W-1:0] div_q_out,
    input  logic [W-1:0] div_r,
    input  logic         div_done
);

    div_arb_state_e state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     done_q, done_d;
    logic           err_q, err_d;
    logic           div_start_q, div_start_d;
    logic [W-1:0]   q_out_q, q_out_d;
    logic [W-1:0]   rem_out_q, rem_out_d;
    logic [W-1:0]   div_q_q, div_q_d;
    logic [W-1:0]   div_m_q, div_m_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [1:0]     win_s;

`ifdef DIV_TIMEOUT_EN
    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // the watchdog limit has no effect when the watchdog is not built
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

    div_arb_rr u_rr (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win_s)
    );

    // next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        grant_d     = 2'b00;
        done_d      = 2'b00;
        err_d       = 1'b0;
        div_start_d = 1'b0;
        q_out_d     = q_out_q;
        rem_out_d   = rem_out_q;
        div_q_d     = div_q_q;
        div_m_d     = div_m_q;
        owner_d     = owner_q;
        last_d      = last_q;
`ifdef DIV_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = win_s;
                    owner_d = win_s[1];
                    div_q_d = win_s[1] ? dividend1 : dividend0;
                    div_m_d = win_s[1] ? divisor1  : divisor0;
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                div_start_d = 1'b1;
                state_d     = ST_WAIT;
`ifdef DIV_TIMEOUT_EN
                cnt_d       = {CNT_W{1'b0}};
`endif
            end
            ST_WAIT: begin
                // a completion in the same cycle as the timeout wins
                if (div_done) begin
                    q_out_d   = div_q_out;
                    rem_out_d = div_r;
                    done_d    = owner_onehot(owner_q);
                    state_d   = ST_RESP;
                end
`ifdef DIV_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    q_out_d   = {W{1'b0}};
                    rem_out_d = {W{1'b0}};
                    done_d    = owner_onehot(owner_q);
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_RESP: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            div_start_q <= 1'b0;
            q_out_q     <= {W{1'b0}};
            rem_out_q   <= {W{1'b0}};
            div_q_q     <= {W{1'b0}};
            div_m_q     <= {W{1'b0}};
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
`ifdef DIV_TIMEOUT_EN
            cnt_q       <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            div_start_q <= div_start_d;
            q_out_q     <= q_out_d;
            rem_out_q   <= rem_out_d;
            div_q_q     <= div_q_d;
            div_m_q     <= div_m_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
`ifdef DIV_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign err       = err_q;
    assign div_start = div_start_q;
    assign q_out     = q_out_q;
    assign rem_out   = rem_out_q;
    assign div_q     = div_q_q;
    assign div_m     = div_m_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider stub.
module tb_div_arbiter;

    localparam int W = 32;
`ifdef DIV_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 1100;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
    logic [1:0]   grant, done;
    logic [W-1:0] q_out, rem_out, div_q, div_m, div_q_out, div_r;
    logic         err, div_start, div_done;

    always #5 clk = ~clk;

    div_arbiter #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .dividend0(dividend0), .divisor0(divisor0),
        .dividend1(dividend1), .divisor1(divisor1),
        .grant(grant), .done(done), .q_out(q_out), .rem_out(rem_out), .err(err),
        .div_start(div_start), .div_q(div_q), .div_m(div_m),
        .div_q_out(div_q_out), .div_r(div_r), .div_done(div_done)
    );

    // reference arithmetic; divide by zero follows the stub's convention
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction
    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // divider stub: completes lat cycles after start unless stalled
    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_qo = '0, m_ro = '0;
    logic         m_done = 1'b0;
    int           lat = 4;
    logic         stall = 1'b0;
    logic         spur = 1'b0;

    assign div_done  = m_done | spur;
    assign div_q_out = spur ? 32'hdeadbeef : m_qo;
    assign div_r     = spur ? 32'hbadc0de0 : m_ro;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (div_start && !stall) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            m_a    <= div_q;
            m_b    <= div_m;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_qo   <= ref_q(m_a, m_b);
                m_ro   <= ref_r(m_a, m_b);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [1:0]   own;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int grant_cnt = 0;
    int start_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (grant != 2'b00) grant_cnt++;
            if (div_start) start_cnt++;
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {30'd0, done}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_owner", {30'd0, done}, {30'd0, mon_e.own});
                    chk("q_out", q_out, mon_e.q);
                    chk("rem_out", rem_out, mon_e.r);
                    chk("err", {31'd0, err}, {31'd0, mon_e.e});
                end
            end
        end
    end

    // reference arbitration state
    logic [1:0]   pend = 2'b00;
    logic [W-1:0] opa[2];
    logic [W-1:0] opb[2];
    int           last_m = 1;

    task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[i] = 1'b1;
        opa[i]  = a;
        opb[i]  = b;
        if (i == 0) begin dividend0 = a; divisor0 = b; end
        else        begin dividend1 = a; divisor1 = b; end
        req = pend;
    endtask

    task automatic serve_one(output int win);
        int n;
        logic [1:0] expg;
        win  = (pend == 2'b11) ? ((last_m == 1) ? 0 : 1) : (pend[0] ? 0 : 1);
        expg = (win == 1) ? 2'b10 : 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (grant == 2'b00 && n < 400);
        if (grant == 2'b00) begin
            chk("grant_timeout", {30'd0, grant}, {30'd0, expg});
        end else begin
            chk("grant_owner", {30'd0, grant}, {30'd0, expg});
            sb.push_back('{own: expg, q: ref_q(opa[win], opb[win]), r: ref_r(opa[win], opb[win]), e: 1'b0});
        end
        last_m = win;
        pend[win] = 1'b0;
        req = pend;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < TO + 2000) begin @(negedge clk); n++; end
        if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_m = 1;
        pend = 2'b00;
        req = 2'b00;
    endtask

    initial begin
        int w;
        int n;
        logic seen_done, seen_err;
        rst = 1'b1; req = 2'b00;
        dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_div_start", {31'd0, div_start}, 32'd0);
        chk("rst_q_out", q_out, 32'd0);
        chk("rst_rem_out", rem_out, 32'd0);
        chk("rst_div_q", div_q, 32'd0);
        chk("rst_div_m", div_m, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single job 100/7 with fixed latency and exact handshake timing
        lat = 10;
        raise(0, 32'd100, 32'd7);
        @(negedge clk);
        chk("grant_latency", {30'd0, grant}, 32'd1);
        sb.push_back('{own: 2'b01, q: 32'd14, r: 32'd2, e: 1'b0});
        pend = 2'b00; req = 2'b00; last_m = 0;
        @(negedge clk);
        chk("start_latency", {31'd0, div_start}, 32'd1);
        chk("div_q_held", div_q, 32'd100);
        chk("div_m_held", div_m, 32'd7);
        drain();
        chk("start_count", start_cnt, 32'd1);

        // contention after reset alternates starting with requester 0
        pulse_reset();
        lat = 3;
        raise(0, 32'd9, 32'd2);
        raise(1, 32'd9, 32'd2);
        for (int k = 0; k < 4; k++) begin
            serve_one(w);
            raise(w, 32'd9, 32'd2);
        end
        pend = 2'b00; req = 2'b00;
        drain();

        // spurious completion in IDLE must be ignored
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("q_hold_spur", q_out, 32'd4);
        chk("r_hold_spur", rem_out, 32'd1);
        raise(1, 32'd50, 32'd5);
        serve_one(w);
        drain();
        chk("q_after_spur", q_out, 32'd10);
        chk("r_after_spur", rem_out, 32'd0);

        // reset during WAIT, then a late completion
        lat = 12;
        raise(0, 32'd77, 32'd3);
        @(negedge clk);
        chk("grant_pre_rst", {30'd0, grant}, 32'd1);
        pend = 2'b00; req = 2'b00;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("done_in_rst", {30'd0, done}, 32'd0);
        rst = 1'b0; last_m = 1;
        repeat (15) @(negedge clk);
        chk("q_after_rst", q_out, 32'd0);
        raise(0, 32'd40, 32'd6);
        @(negedge clk);
        chk("grant_after_rst", {30'd0, grant}, 32'd1);
        sb.push_back('{own: 2'b01, q: 32'd6, r: 32'd4, e: 1'b0});
        pend = 2'b00; req = 2'b00; last_m = 0;
        drain();

        // divider that never completes
        stall = 1'b1;
        raise(1, 32'd123, 32'd4);
        @(negedge clk);
        chk("grant_stall", {30'd0, grant}, 32'd2);
        pend = 2'b00; req = 2'b00; last_m = 1;
        @(negedge clk);
        chk("start_stall", {31'd0, div_start}, 32'd1);
`ifdef DIV_TIMEOUT_EN
        sb.push_back('{own: 2'b10, q: 32'd0, r: 32'd0, e: 1'b1});
        n = 0;
        while (done == 2'b00 && n < 200) begin @(negedge clk); n++; end
        chk("timeout_cycles", n, TO);
        drain();
        stall = 1'b0;
`else
        seen_done = 1'b0; seen_err = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (done != 2'b00) seen_done = 1'b1;
            if (err) seen_err = 1'b1;
        end
        chk("stall_no_done", {31'd0, seen_done}, 32'd0);
        chk("stall_err_low", {31'd0, seen_err}, 32'd0);
        stall = 1'b0;
        pulse_reset();
        repeat (2) @(negedge clk);
`endif

        // randomized two-requester traffic
        for (int it = 0; it < 60; it++) begin
            lat = $urandom_range(1, 15);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    raise(i, $urandom, ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31)));
            end
            if (pend == 2'b00)
                raise($urandom_range(0, 1), $urandom, ($urandom >> $urandom_range(0, 31)) | 32'd1);
            serve_one(w);
        end
        while (pend != 2'b00) serve_one(w);
        drain();
        chk("start_per_grant", start_cnt, grant_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
